mul_arbiter: RTL

- Round-robin arbiter and sequencer that shares one half-precision multiplier (mod_Multiply: in_A/in_B/in_En in, out_Out/out_Ready out) between NUM_REQ neuron-datapath requesters.
- Sits between neuron-update units and the single multiplier instance.
- Each requester presents an operand pair and holds a request. The arbiter issues one operation at a time and returns the 16-bit product with a one-cycle done pulse to the owner.

---
 rtl/mul_arb_pkg.sv | 13 +
 rtl/mul_arbiter_rr_pick.sv | 27 ++
 rtl/mul_arbiter.sv | 116 +++++++++++
 3 files changed

// File: rtl/mul_arb_pkg.sv
// Shared types and constants for the half-precision multiplier arbiter.
package mul_arb_pkg;

  localparam int unsigned FP16_W    = 16;
  localparam logic [15:0] FP16_QNAN = 16'h7E00;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mul_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request scanning last+1, last+2, ... with wrap.
module rr_pick #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] in_Req,
  input  logic [IDX_W-1:0]   last,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand = IDX_W'((32'(last) + i) % NUM_REQ);
      if (!any && in_Req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/mul_arbiter.sv
// Round-robin sequencer sharing one FP16 multiplier among NUM_REQ requesters.
// Define MUL_TIMEOUT_EN to add a WAIT-state watchdog that returns qNaN with out_Error.
module mul_arbiter
  import mul_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned IDX_W          = 2,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        in_Req,
  input  logic [FP16_W*NUM_REQ-1:0] in_A,
  input  logic [FP16_W*NUM_REQ-1:0] in_B,
  output logic [NUM_REQ-1:0]        out_Grant,
  output logic [NUM_REQ-1:0]        out_Done,
  output logic [FP16_W-1:0]         out_Result,
  output logic                      out_Error,
  output logic                      mul_En,
  output logic [FP16_W-1:0]         mul_A,
  output logic [FP16_W-1:0]         mul_B,
  input  logic [FP16_W-1:0]         mul_Out,
  input  logic                      mul_Ready
);

  arb_state_t       state;
  logic [IDX_W-1:0] last;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;

  rr_pick #(
    .NUM_REQ(NUM_REQ),
    .IDX_W  (IDX_W)
  ) u_pick (
    .in_Req(in_Req),
    .last  (last),
    .idx   (pick_idx),
    .any   (pick_any)
  );

`ifdef MUL_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt;
`else
  logic unused_timeout;
  assign unused_timeout = |TIMEOUT_CYCLES;
  assign out_Error      = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last       <= IDX_W'(NUM_REQ - 1);
      idx        <= '0;
      mul_A      <= '0;
      mul_B      <= '0;
      mul_En     <= 1'b0;
      out_Grant  <= '0;
      out_Done   <= '0;
      out_Result <= '0;
`ifdef MUL_TIMEOUT_EN
      out_Error  <= 1'b0;
      wait_cnt   <= '0;
`endif
    end else begin
      // Done, error and enable are single-cycle pulses unless re-asserted below.
      out_Done <= '0;
      mul_En   <= 1'b0;
`ifdef MUL_TIMEOUT_EN
      out_Error <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (pick_any) begin
            idx       <= pick_idx;
            mul_A     <= in_A[FP16_W*pick_idx +: FP16_W];
            mul_B     <= in_B[FP16_W*pick_idx +: FP16_W];
            out_Grant <= NUM_REQ'(1) << pick_idx;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          mul_En <= 1'b1;
          state  <= WAIT;
`ifdef MUL_TIMEOUT_EN
          wait_cnt <= '0;
`endif
        end
        WAIT: begin
          if (mul_Ready) begin
            out_Result <= mul_Out;
            out_Done   <= NUM_REQ'(1) << idx;
            out_Grant  <= '0;
            last       <= idx;
            state      <= IDLE;
          end
`ifdef MUL_TIMEOUT_EN
          else if (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            out_Result <= FP16_QNAN;
            out_Done   <= NUM_REQ'(1) << idx;
            out_Error  <= 1'b1;
            out_Grant  <= '0;
            last       <= idx;
            state      <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
